// File: rtl/processors_unit.sv
// Alpha-composition frame engine: blends a switch-selected foreground colour over a
// generated background and streams a 400x400 frame as packed R/G/B 4-pixel words.
// Latency: GPIOEn two cycles after swInicio is sampled high, then one word per cycle (R,G,B).
// Backpressure: none; the GPIO consumer must accept every strobe as it is presented.
//
// Ports:
//   clk, rst (async, active-low)       single clock domain
//   swInicio                           frame start level
//   swIn{R,G,B}{0,25,75,100}           foreground level per channel
//   swTD{0,25,75,100}                  alpha level
//   swH/swV/swD/swP                    background select (H>V>D>P)
//   GPIO[31:0]                         4 lanes of one channel, lane 0 = pixel x
//   GPIOEnR/G/B, GPIOEn                data strobes / frame-start strobe
// Build option: define BG_PATTERN_EN to enable the checker background on swP.
// Coordinates are held in 9 bits, so WIDTH and HEIGHT must not exceed 512.
module processors_unit #(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swInicio,
  input  logic        swInR0,
  input  logic        swInR25,
  input  logic        swInR75,
  input  logic        swInR100,
  input  logic        swInG0,
  input  logic        swInG25,
  input  logic        swInG75,
  input  logic        swInG100,
  input  logic        swInB0,
  input  logic        swInB25,
  input  logic        swInB75,
  input  logic        swInB100,
  input  logic        swTD0,
  input  logic        swTD25,
  input  logic        swTD75,
  input  logic        swTD100,
  input  logic        swH,
  input  logic        swV,
  input  logic        swD,
  input  logic        swP,
  output logic [31:0] GPIO,
  output logic        GPIOEnR,
  output logic        GPIOEnG,
  output logic        GPIOEnB,
  output logic        GPIOEn
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_R, ST_G, ST_B, ST_DONE} state_t;
  typedef enum logic [2:0] {BG_NONE, BG_H, BG_V, BG_D, BG_P} bg_sel_t;

  // The "0" level selects produce the same value as no selection at all.
  logic unused_zero_sel;
`ifdef BG_PATTERN_EN
  assign unused_zero_sel = swInR0 | swInG0 | swInB0 | swTD0;
`else
  assign unused_zero_sel = swInR0 | swInG0 | swInB0 | swTD0 | swP;
`endif

  // Priority encoders for the level switches: {100, 75, 25}.
  function automatic logic [7:0] colour_level(input logic [2:0] s);
    logic [7:0] v;
    v = 8'd0;
    if (s[2])      v = 8'd255;
    else if (s[1]) v = 8'd191;
    else if (s[0]) v = 8'd64;
    return v;
  endfunction

  function automatic logic [8:0] alpha_level(input logic [2:0] s);
    logic [8:0] v;
    v = 9'd0;
    if (s[2])      v = 9'd256;
    else if (s[1]) v = 9'd192;
    else if (s[0]) v = 9'd64;
    return v;
  endfunction

  function automatic logic [7:0] bg_of(input logic [8:0] px, input logic [8:0] py,
                                        input bg_sel_t sel);
    logic [9:0] diag;
    logic [7:0] v;
    diag = {1'b0, px} + {1'b0, py};
    v    = 8'h00;
    case (sel)
      BG_H:    v = px[8:1];
      BG_V:    v = py[8:1];
      BG_D:    v = diag[9:2];
`ifdef BG_PATTERN_EN
      BG_P:    v = (px[5] ^ py[5]) ? 8'hff : 8'h00;
`endif
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // a*fg + (256-a)*bg is at most 256*255, so the shifted result fits 8 bits.
  function automatic logic [7:0] blend(input logic [7:0] fg, input logic [7:0] bg,
                                        input logic [8:0] a);
    logic [16:0] acc;
    acc = 17'(a) * 17'(fg) + 17'(9'd256 - a) * 17'(bg);
    return 8'(acc >> 8);
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [31:0] gpio_q, gpio_d;
  logic        en_r_q, en_r_d, en_g_q, en_g_d, en_b_q, en_b_d, en_f_q, en_f_d;
  logic [7:0]  fg_r_q, fg_r_d, fg_g_q, fg_g_d, fg_b_q, fg_b_d;
  logic [8:0]  alpha_q, alpha_d;
  bg_sel_t     bg_sel_q, bg_sel_d;

  logic [7:0]  chan_fg;
  logic [31:0] word;

  // Word for the channel being emitted this cycle, lanes x..x+3 of row y.
  always_comb begin
    word = '0;
    case (state_q)
      ST_G:    chan_fg = fg_g_q;
      ST_B:    chan_fg = fg_b_q;
      default: chan_fg = fg_r_q;
    endcase
    for (int l = 0; l < 4; l++) begin
      word[8*l +: 8] = blend(chan_fg, bg_of(x_q + 9'(l), y_q, bg_sel_q), alpha_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    gpio_d   = gpio_q;
    en_r_d   = 1'b0;
    en_g_d   = 1'b0;
    en_b_d   = 1'b0;
    en_f_d   = 1'b0;
    fg_r_d   = fg_r_q;
    fg_g_d   = fg_g_q;
    fg_b_d   = fg_b_q;
    alpha_d  = alpha_q;
    bg_sel_d = bg_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (swInicio) begin
          fg_r_d  = colour_level({swInR100, swInR75, swInR25});
          fg_g_d  = colour_level({swInG100, swInG75, swInG25});
          fg_b_d  = colour_level({swInB100, swInB75, swInB25});
          alpha_d = alpha_level({swTD100, swTD75, swTD25});
          if (swH)      bg_sel_d = BG_H;
          else if (swV) bg_sel_d = BG_V;
          else if (swD) bg_sel_d = BG_D;
`ifdef BG_PATTERN_EN
          else if (swP) bg_sel_d = BG_P;
`endif
          else          bg_sel_d = BG_NONE;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        en_f_d  = 1'b1;
        gpio_d  = '0;
        state_d = ST_R;
      end
      ST_R: begin
        en_r_d  = 1'b1;
        gpio_d  = word;
        state_d = ST_G;
      end
      ST_G: begin
        en_g_d  = 1'b1;
        gpio_d  = word;
        state_d = ST_B;
      end
      ST_B: begin
        en_b_d  = 1'b1;
        gpio_d  = word;
        state_d = ST_R;
        if (x_q == 9'(WIDTH - 4)) begin
          x_d = '0;
          if (y_q == 9'(HEIGHT - 1)) begin
            y_d     = '0;
            state_d = ST_DONE;
          end else begin
            y_d = y_q + 9'd1;
          end
        end else begin
          x_d = x_q + 9'd4;
        end
      end
      ST_DONE: begin
        if (!swInicio) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      gpio_q   <= '0;
      en_r_q   <= 1'b0;
      en_g_q   <= 1'b0;
      en_b_q   <= 1'b0;
      en_f_q   <= 1'b0;
      fg_r_q   <= '0;
      fg_g_q   <= '0;
      fg_b_q   <= '0;
      alpha_q  <= '0;
      bg_sel_q <= BG_NONE;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gpio_q   <= gpio_d;
      en_r_q   <= en_r_d;
      en_g_q   <= en_g_d;
      en_b_q   <= en_b_d;
      en_f_q   <= en_f_d;
      fg_r_q   <= fg_r_d;
      fg_g_q   <= fg_g_d;
      fg_b_q   <= fg_b_d;
      alpha_q  <= alpha_d;
      bg_sel_q <= bg_sel_d;
    end
  end

  assign GPIO    = gpio_q;
  assign GPIOEnR = en_r_q;
  assign GPIOEnG = en_g_q;
  assign GPIOEnB = en_b_q;
  assign GPIOEn  = en_f_q;

endmodule

// File: tb/tb_processors_unit.sv
// Testbench for processors_unit: frames are run on a reduced-height instance
// (full 400-pixel rows, 10 rows) and every strobe is scored against a reference
// built from the blending rules.
module tb_processors_unit;
  localparam int W     = 400;
  localparam int H     = 10;
  localparam int WORDS = (W / 4) * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_start;
  logic [3:0]  sw_r, sw_g, sw_b, sw_td, sw_bg;  // [0]=0,[1]=25,[2]=75,[3]=100 ; bg [0]=H,[1]=V,[2]=D,[3]=P
  logic [31:0] gpio;
  logic        en_r, en_g, en_b, en_f;

  always #5 clk = ~clk;

  processors_unit #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .swInicio(sw_start),
    .swInR0(sw_r[0]), .swInR25(sw_r[1]), .swInR75(sw_r[2]), .swInR100(sw_r[3]),
    .swInG0(sw_g[0]), .swInG25(sw_g[1]), .swInG75(sw_g[2]), .swInG100(sw_g[3]),
    .swInB0(sw_b[0]), .swInB25(sw_b[1]), .swInB75(sw_b[2]), .swInB100(sw_b[3]),
    .swTD0(sw_td[0]), .swTD25(sw_td[1]), .swTD75(sw_td[2]), .swTD100(sw_td[3]),
    .swH(sw_bg[0]), .swV(sw_bg[1]), .swD(sw_bg[2]), .swP(sw_bg[3]),
    .GPIO(gpio), .GPIOEnR(en_r), .GPIOEnG(en_g), .GPIOEnB(en_b), .GPIOEn(en_f)
  );

  typedef struct {
    int          kind;  // 0 frame start, 1 R, 2 G, 3 B
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_last;
  int          checks   = 0;
  int          failures = 0;
  int          cnt_f, cnt_r, cnt_g, cnt_b;
  logic [31:0] first_r, first_g, first_b, last_r, last_b;

  // ---------------- reference model ----------------
  function automatic int lvl(input logic [3:0] s, input int v25, input int v75, input int v100);
    if (s[3]) return v100;
    if (s[2]) return v75;
    if (s[1]) return v25;
    return 0;
  endfunction

  function automatic int bg_model(input int mode, input int x, input int y);
    case (mode)
      1:       return x / 2;
      2:       return y / 2;
      3:       return (x + y) / 4;
      4:       return (((x / 32) % 2) != ((y / 32) % 2)) ? 255 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic push_frame();
    int fg[3];
    int a, mode, v;
    logic [31:0] w;
    fg[0] = lvl(sw_r, 64, 191, 255);
    fg[1] = lvl(sw_g, 64, 191, 255);
    fg[2] = lvl(sw_b, 64, 191, 255);
    a     = lvl(sw_td, 64, 192, 256);
    mode  = sw_bg[0] ? 1 : sw_bg[1] ? 2 : sw_bg[2] ? 3 : 0;
`ifdef BG_PATTERN_EN
    if (mode == 0 && sw_bg[3]) mode = 4;
`endif
    exp_q.push_back('{0, 32'h0});
    w = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x += 4) begin
        for (int ch = 0; ch < 3; ch++) begin
          for (int l = 0; l < 4; l++) begin
            v = (a * fg[ch] + (256 - a) * bg_model(mode, x + l, y)) / 256;
            w[8*l +: 8] = 8'(v);
          end
          exp_q.push_back('{ch + 1, w});
        end
      end
    end
    exp_last = w;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    int   n, k;
    exp_t e;
    n = int'(en_f) + int'(en_r) + int'(en_g) + int'(en_b);
    k = en_f ? 0 : en_r ? 1 : en_g ? 2 : 3;
    if (n > 1) begin
      checks++;
      failures++;
      $display("FAIL strobe_overlap got=%0d strobes want<=1", n);
    end else if (n == 1) begin
      case (k)
        0: cnt_f++;
        1: begin if (cnt_r == 0) first_r = gpio; last_r = gpio; cnt_r++; end
        2: begin if (cnt_g == 0) first_g = gpio; cnt_g++; end
        default: begin if (cnt_b == 0) first_b = gpio; last_b = gpio; cnt_b++; end
      endcase
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe kind=%0d got=%h want=no strobe", k, gpio);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.dat !== gpio) begin
          failures++;
          $display("FAIL word got kind=%0d dat=%h want kind=%0d dat=%h", k, gpio, e.kind, e.dat);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_gpio"}, gpio, 32'h0);
    chk({name, "_en"},   32'(en_f), 32'h0);
    chk({name, "_enr"},  32'(en_r), 32'h0);
    chk({name, "_eng"},  32'(en_g), 32'h0);
    chk({name, "_enb"},  32'(en_b), 32'h0);
  endtask

  function automatic logic [3:0] rbits();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  task automatic set_cfg(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                         input logic [3:0] td, input logic [3:0] bg);
    sw_r = r; sw_g = g; sw_b = b; sw_td = td; sw_bg = bg;
  endtask

  task automatic clear_counts();
    cnt_f = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0;
  endtask

  task automatic start_frame(input bit scramble);
    clear_counts();
    push_frame();
    @(posedge clk); #1;
    sw_start = 1'b1;
    if (scramble) begin
      // Switch changes once the frame has started must not affect it.
      repeat (20) @(posedge clk);
      #1;
      set_cfg(rbits(), rbits(), rbits(), rbits(), rbits());
    end
  endtask

  task automatic finish_frame();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3 * WORDS + 200; i++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout got=%0d words left want=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_hold", gpio, exp_last);
    sw_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_start", 32'(cnt_f), 32'd1);
    chk("cnt_r", 32'(cnt_r), 32'(WORDS));
    chk("cnt_g", 32'(cnt_g), 32'(WORDS));
    chk("cnt_b", 32'(cnt_b), 32'(WORDS));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    sw_start = 1'b0;
    set_cfg(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // R25 G25 B75, alpha 75, diagonal background
    set_cfg(4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100);
    start_frame(1'b1);
    finish_frame();
    chk("a_first_r", first_r, 32'h30303030);
    chk("a_first_g", first_g, 32'h30303030);
    chk("a_first_b0", 32'(first_b[7:0]), 32'h8f);
    chk("a_last_r3", 32'(last_r[31:24]), 32'h49);  // x=399,y=9: bg=102
    chk("a_last_b3", 32'(last_b[31:24]), 32'ha8);

    // alpha 0, horizontal: output is x>>1
    set_cfg(rbits(), rbits(), rbits(), 4'b0001, 4'b0001);
    start_frame(1'b0);
    finish_frame();
    chk("h_first_r", first_r, 32'h01010000);
    chk("h_last_r3", 32'(last_r[31:24]), 32'hc7);

    // alpha 100, R100: red saturated everywhere
    set_cfg(4'b1000, rbits(), rbits(), 4'b1000, rbits());
    start_frame(1'b1);
    finish_frame();
    chk("full_first_r", first_r, 32'hffffffff);
    chk("full_last_r", last_r, 32'hffffffff);

    // checker only, alpha 0
    set_cfg(rbits(), rbits(), rbits(), 4'b0001, 4'b1000);
    start_frame(1'b0);
    finish_frame();
    chk("p_first_r", first_r, 32'h00000000);
`ifndef BG_PATTERN_EN
    chk("p_last_r", last_r, 32'h00000000);
`endif

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      set_cfg(rbits(), rbits(), rbits(), rbits(), rbits());
      start_frame(1'b1);
      finish_frame();
    end

    // reset in the middle of a frame, swInicio held high throughout
    set_cfg(rbits(), rbits(), rbits(), rbits(), rbits());
    start_frame(1'b0);
    repeat ($urandom_range(100, 1500)) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("midreset");
    exp_q.delete();
    clear_counts();
    push_frame();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
